mac_accum_param_2: RTL and testbench

Signed multiply-accumulate front end for the layer-2 convolution datapath. It takes a stream of 16-bit feature/weight pairs and forms a 44-bit dot product over each kernel window of KERNEL_LEN products. It publishes the window total on `result` together with the window beat counter `count_sload`. It drives the truncating ReLU stage, which samples `result` when `count_sload == 2`.

---
 rtl/mac_accum_param_2_pkg.sv | 9 +
 rtl/mac_accum_param_2_mult.sv | 40 ++++
 rtl/mac_accum_param_2.sv | 99 +++++++++
 tb/tb_mac_accum_param_2.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mac_accum_param_2_pkg.sv
// Shared constants for the layer-2 multiply-accumulate front end.
package mac_accum_param_2_pkg;

  localparam int DEF_DATA_WIDTH           = 16;
  localparam int DEF_ACCUM_DATA_WIDTH     = 44;
  localparam int DEF_KERNEL_LEN           = 25;
  localparam int DEF_COUNT_SLOAD_BITWIDTH = 5;

endpackage

// File: rtl/mac_accum_param_2_mult.sv
// Signed DATA_WIDTH x DATA_WIDTH multiplier with a registered product (stage 1).
module mult_param_2
  import mac_accum_param_2_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      load,
  input  logic [DATA_WIDTH-1:0]     a,
  input  logic [DATA_WIDTH-1:0]     b,
  output logic [2*DATA_WIDTH-1:0]   prod
);

  localparam int PW = 2 * DATA_WIDTH;

  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] b_ext;
  logic [PW-1:0]        prod_q;
  logic [PW-1:0]        prod_d;

  // Extend both operands to full product width so the low PW bits are the exact signed product.
  assign a_ext = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
  assign b_ext = {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};

  always_comb begin
    // NOTE: the hold value is assigned first so every path writes prod_d and no latch is inferred.
    prod_d = prod_q;
    if (load) prod_d = a_ext * b_ext;
  end

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (!reset) prod_q <= '0;
    else        prod_q <= prod_d;
  end

  assign prod = prod_q;

endmodule

// File: rtl/mac_accum_param_2.sv
// Windowed signed dot product: beat counter, registered multiply, sload accumulator.
module mac_accum_param_2
  import mac_accum_param_2_pkg::*;
#(
  parameter int DATA_WIDTH           = DEF_DATA_WIDTH,
  parameter int ACCUM_DATA_WIDTH     = DEF_ACCUM_DATA_WIDTH,
  parameter int KERNEL_LEN           = DEF_KERNEL_LEN,
  parameter int COUNT_SLOAD_BITWIDTH = DEF_COUNT_SLOAD_BITWIDTH
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            in_valid,
  input  logic [DATA_WIDTH-1:0]           data_in,
  input  logic [DATA_WIDTH-1:0]           weight_in,
  output logic [ACCUM_DATA_WIDTH-1:0]     result,
  output logic [COUNT_SLOAD_BITWIDTH-1:0] count_sload,
  output logic                            result_valid
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int AW = ACCUM_DATA_WIDTH;
  localparam int CW = COUNT_SLOAD_BITWIDTH;
  localparam logic [CW-1:0] LAST_IDX = CW'(KERNEL_LEN - 1);

  logic          accept;
  logic [PW-1:0] prod;
  logic [AW-1:0] prod_ext;

  logic [CW-1:0] count_q,  count_d;
  logic [CW-1:0] idx_q,    idx_d;
  logic          v1_q,     v1_d;
  logic [AW-1:0] acc_q,    acc_d;
  logic [AW-1:0] result_q, result_d;
  logic          rv_q,     rv_d;

  assign accept = enable && in_valid;

  mult_param_2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mult (
    .clock (clock),
    .reset (reset),
    .load  (accept),
    .a     (data_in),
    .b     (weight_in),
    .prod  (prod)
  );

  assign prod_ext = {{(AW - PW){prod[PW-1]}}, prod};

  always_comb begin
    count_d  = count_q;
    idx_d    = idx_q;
    v1_d     = v1_q;
    acc_d    = acc_q;
    result_d = result_q;
    rv_d     = 1'b0;

    if (accept) begin
      idx_d   = count_q;
      count_d = (count_q == LAST_IDX) ? '0 : count_q + 1'b1;
    end

    if (enable) v1_d = in_valid;

    // Index 0 reloads the accumulator, which drops the previous window without a separate clear.
    if (enable && v1_q) begin
      acc_d = (idx_q == '0) ? prod_ext : acc_q + prod_ext;
      if (idx_q == LAST_IDX) begin
        result_d = acc_q + prod_ext;
        rv_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q  <= '0;
      idx_q    <= '0;
      v1_q     <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      rv_q     <= 1'b0;
    end else begin
      count_q  <= count_d;
      idx_q    <= idx_d;
      v1_q     <= v1_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      rv_q     <= rv_d;
    end
  end

  assign result       = result_q;
  assign count_sload  = count_q;
  assign result_valid = rv_q;

endmodule

// File: tb/tb_mac_accum_param_2.sv
// Self-checking bench for mac_accum_param_2 against a window-sum reference model.
module tb_mac_accum_param_2;

  localparam int DW = 16;
  localparam int AW = 44;
  localparam int K  = 25;
  localparam int CW = 5;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 enable;
  logic                 in_valid;
  logic signed [DW-1:0] data_in;
  logic signed [DW-1:0] weight_in;
  logic [AW-1:0]        result;
  logic [CW-1:0]        count_sload;
  logic                 result_valid;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: beats accepted in window, running window sum, completed total awaiting publication.
  int     m_count;
  longint m_sum;
  bit     m_pending;
  longint m_pend_val;
  longint m_result;
  bit     m_rv;

  mac_accum_param_2 dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .in_valid     (in_valid),
    .data_in      (data_in),
    .weight_in    (weight_in),
    .result       (result),
    .count_sload  (count_sload),
    .result_valid (result_valid)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string name, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_result(input string name, input longint exp);
    logic [AW-1:0] e;
    longint        ev;
    ev = exp;
    e  = ev[AW-1:0];
    n_checks++;
    if (result !== e) begin
      n_fail++;
      $display("FAIL %s: result got %0d (0x%h) expected %0d (0x%h)", name, $signed(result), result, exp, e);
    end
  endtask

  // One clock: drive inputs, advance model at the edge, compare all outputs at the falling edge.
  task automatic cycle(input bit rst, input bit en, input bit vld,
                       input logic signed [DW-1:0] d, input logic signed [DW-1:0] w);
    reset     = !rst;
    enable    = en;
    in_valid  = vld;
    data_in   = d;
    weight_in = w;
    @(posedge clock);
    if (rst) begin
      m_count = 0; m_sum = 0; m_pending = 0; m_result = 0; m_rv = 0;
    end else if (en) begin
      m_rv = 0;
      if (m_pending) begin
        m_result  = m_pend_val;
        m_rv      = 1;
        m_pending = 0;
      end
      if (vld) begin
        m_sum = ((m_count == 0) ? 64'sd0 : m_sum) + longint'(d) * longint'(w);
        if (m_count == K - 1) begin
          m_pending  = 1;
          m_pend_val = m_sum;
          m_count    = 0;
        end else begin
          m_count++;
        end
      end
    end else begin
      m_rv = 0;
    end
    @(negedge clock);
    check_val("model_count_sload", count_sload, m_count);
    check_val("model_result_valid", result_valid, m_rv);
    check_result("model_result", m_result);
  endtask

  task automatic idle();
    cycle(0, 1, 0, 16'sd0, 16'sd0);
  endtask

  task automatic window_const(input logic signed [DW-1:0] d, input logic signed [DW-1:0] w);
    for (int i = 0; i < K; i++) cycle(0, 1, 1, d, w);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) cycle(1, 1, 1, DW'($urandom), DW'($urandom));
    check_val("reset_result", result, 0);
    check_val("reset_count_sload", count_sload, 0);
    check_val("reset_result_valid", result_valid, 0);
  endtask

  task automatic test_ones();
    window_const(16'sd1, 16'sd1);
    check_val("ones_no_early_valid", result_valid, 0);
    check_val("ones_count_wrapped", count_sload, 0);
    idle();
    check_result("ones_total", 25);
    check_val("ones_valid_pulse", result_valid, 1);
    idle();
    check_val("ones_valid_one_cycle", result_valid, 0);
    check_result("ones_total_hold", 25);
  endtask

  task automatic test_negative();
    window_const(-16'sd3, 16'sd100);
    idle();
    check_result("neg_total", -7500);
    check_val("neg_sign_bits", result[AW-1:32], 12'hfff);
    idle();
  endtask

  task automatic test_back_to_back();
    window_const(16'sd2, 16'sd2);
    for (int i = 0; i < K; i++) begin
      cycle(0, 1, 1, 16'sd1, -16'sd1);
      if (i == 0) check_val("b2b_valid_A", result_valid, 1);
      if (i == 1) begin
        check_val("b2b_count_is_2", count_sload, 2);
        check_result("b2b_A_stable_at_2", 100);
      end
    end
    idle();
    check_result("b2b_B_total", -25);
    check_val("b2b_valid_B", result_valid, 1);
    idle();
  endtask

  task automatic test_gaps_stall();
    logic signed [DW-1:0] dv [K];
    logic signed [DW-1:0] wv [K];
    longint total;
    int     i;
    bit     stalled;
    total = 0;
    for (int j = 0; j < K; j++) begin
      dv[j] = DW'($urandom);
      wv[j] = DW'($urandom);
      total += longint'(dv[j]) * longint'(wv[j]);
    end
    for (int j = 0; j < K; j++) cycle(0, 1, 1, dv[j], wv[j]);
    idle();
    check_result("gapfree_total", total);
    i = 0;
    stalled = 0;
    while (i < K) begin
      if (i == 12 && !stalled) begin
        for (int s = 0; s < 3; s++) begin
          cycle(0, 0, 1, DW'($urandom), DW'($urandom));
          check_val("stall_count_frozen", count_sload, 12);
          check_val("stall_no_valid", result_valid, 0);
        end
        stalled = 1;
      end else if ($urandom_range(0, 2) == 0) begin
        cycle(0, 1, 0, DW'($urandom), DW'($urandom));
      end else begin
        cycle(0, 1, 1, dv[i], wv[i]);
        i++;
      end
    end
    for (int s = 0; s < 2; s++) begin
      cycle(0, 0, 1, DW'($urandom), DW'($urandom));
      check_val("late_stall_no_valid", result_valid, 0);
    end
    idle();
    check_result("gappy_total", total);
    check_val("gappy_valid_after_stall", result_valid, 1);
    idle();
  endtask

  task automatic test_max();
    window_const(-16'sd32768, -16'sd32768);
    idle();
    check_result("max_total", 64'sd26843545600);
    check_val("max_valid", result_valid, 1);
    idle();
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 10; i++) cycle(0, 1, 1, 16'sd7, 16'sd9);
    cycle(1, 1, 1, 16'sd7, 16'sd9);
    check_val("midrst_result", result, 0);
    check_val("midrst_count", count_sload, 0);
    check_val("midrst_valid", result_valid, 0);
    window_const(16'sd1, 16'sd1);
    idle();
    check_result("midrst_next_window", 25);
    idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      cycle(0, ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0),
            DW'($urandom), DW'($urandom));
    end
    for (int n = 0; n < 3; n++) idle();
  endtask

  initial begin
    m_count = 0; m_sum = 0; m_pending = 0; m_pend_val = 0; m_result = 0; m_rv = 0;
    reset = 1'b0; enable = 1'b0; in_valid = 1'b0; data_in = '0; weight_in = '0;
    test_reset();
    test_ones();
    test_negative();
    test_back_to_back();
    test_gaps_stall();
    test_max();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
